// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and constants for the core-to-memory bus arbiter.
package mips_cpu_bus_pkg;

  localparam int unsigned BUS_W = 32;
  localparam int unsigned BE_W  = 4;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_DATA,
    ARB_FETCH,
    ARB_STEP,
    ARB_HALT,
    ARB_ERROR
  } arb_state_t;

  localparam logic [BE_W-1:0]  AVM_BE_WORD  = 4'hF;
  localparam logic [BUS_W-1:0] RESET_VECTOR = 32'hBFC00000;

endpackage

// File: rtl/mips_cpu_wait_timer.sv
// Per-transfer count of consecutive waitrequest cycles; flags the cycle that reaches WAIT_LIMIT.
module mips_cpu_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic active_i,
  input  logic wait_i,
  output logic limit_hit_c
);

  localparam int unsigned     CNT_W    = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating so an unlimited configuration never wraps into a false hit.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (active_i && wait_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign limit_hit_c = (WAIT_LIMIT != 0) && active_i && wait_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// Shares one Avalon-MM master between core data and fetch ports, pacing the core one step at a time.
// Optional perf counters enabled by defining MIPS_ARB_PERF_EN.
module mips_cpu_bus_arbiter
  import mips_cpu_bus_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 1024
`ifdef MIPS_ARB_PERF_EN
  , parameter int unsigned PERF_W = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_active,
  output logic             core_clk_enable,
  input  logic [BUS_W-1:0] instr_address,
  output logic [BUS_W-1:0] instr_readdata,
  input  logic             data_read,
  input  logic             data_write,
  input  logic [BUS_W-1:0] data_address,
  input  logic [BE_W-1:0]  data_byteenable,
  input  logic [BUS_W-1:0] data_writedata,
  output logic [BUS_W-1:0] data_readdata,
  output logic [BUS_W-1:0] avm_address,
  output logic             avm_read,
  output logic             avm_write,
  output logic [BE_W-1:0]  avm_byteenable,
  output logic [BUS_W-1:0] avm_writedata,
  input  logic [BUS_W-1:0] avm_readdata,
  input  logic             avm_waitrequest,
  output logic             bus_error
`ifdef MIPS_ARB_PERF_EN
  , output logic [PERF_W-1:0] perf_steps,
  output logic [PERF_W-1:0] perf_wait_cycles
`endif
);

  arb_state_t       state_q, state_d;
  logic [BUS_W-1:0] addr_q, addr_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [BE_W-1:0]  be_q, be_d;
  logic [BUS_W-1:0] wdata_q, wdata_d;
  logic [BUS_W-1:0] instr_q, instr_d;
  logic [BUS_W-1:0] dread_q, dread_d;
  logic             cke_q, cke_d;
  logic             err_q, err_d;
  logic             timer_start;
  logic             limit_hit;

  mips_cpu_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk         (clk),
    .reset       (reset),
    .start_i     (timer_start),
    .active_i    (rd_q | wr_q),
    .wait_i      (avm_waitrequest),
    .limit_hit_c (limit_hit)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    instr_d     = instr_q;
    dread_d     = dread_q;
    cke_d       = 1'b0;
    err_d       = err_q;
    timer_start = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (!core_active) begin
          state_d = ARB_HALT;
        end else if (data_read || data_write) begin
          state_d     = ARB_DATA;
          addr_d      = data_address;
          be_d        = data_byteenable;
          wdata_d     = data_writedata;
          wr_d        = data_write;
          rd_d        = !data_write;
          timer_start = 1'b1;
        end else begin
          state_d     = ARB_FETCH;
          addr_d      = instr_address;
          be_d        = AVM_BE_WORD;
          rd_d        = 1'b1;
          wr_d        = 1'b0;
          timer_start = 1'b1;
        end
      end
      ARB_DATA: begin
        if (limit_hit) begin
          state_d = ARB_ERROR;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
        end else if (!avm_waitrequest) begin
          if (rd_q) dread_d = avm_readdata;
          state_d     = ARB_FETCH;
          addr_d      = instr_address;
          be_d        = AVM_BE_WORD;
          rd_d        = 1'b1;
          wr_d        = 1'b0;
          timer_start = 1'b1;
        end
      end
      ARB_FETCH: begin
        if (limit_hit) begin
          state_d = ARB_ERROR;
          rd_d    = 1'b0;
          err_d   = 1'b1;
        end else if (!avm_waitrequest) begin
          instr_d = avm_readdata;
          rd_d    = 1'b0;
          cke_d   = 1'b1;
          state_d = ARB_STEP;
        end
      end
      ARB_STEP:  state_d = ARB_IDLE;
      ARB_HALT:  state_d = ARB_HALT;
      ARB_ERROR: state_d = ARB_ERROR;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      instr_q <= '0;
      dread_q <= '0;
      cke_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      dread_q <= dread_d;
      cke_q   <= cke_d;
      err_q   <= err_d;
    end
  end

  assign core_clk_enable = cke_q;
  assign instr_readdata  = instr_q;
  assign data_readdata   = dread_q;
  assign avm_address     = addr_q;
  assign avm_read        = rd_q;
  assign avm_write       = wr_q;
  assign avm_byteenable  = be_q;
  assign avm_writedata   = wdata_q;
  assign bus_error       = err_q;

`ifdef MIPS_ARB_PERF_EN
  logic [PERF_W-1:0] perf_steps_q, perf_wait_q;

  // Saturating event counters: completed steps and stalled strobe cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_steps_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      if ((state_q == ARB_STEP) && (perf_steps_q != '1))
        perf_steps_q <= perf_steps_q + PERF_W'(1);
      if ((rd_q || wr_q) && avm_waitrequest && (perf_wait_q != '1))
        perf_wait_q <= perf_wait_q + PERF_W'(1);
    end
  end

  assign perf_steps       = perf_steps_q;
  assign perf_wait_cycles = perf_wait_q;
`endif

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Bench for mips_cpu_bus_arbiter: per-cycle expectations built from whole-step descriptions.
module tb_mips_cpu_bus_arbiter;
  import mips_cpu_bus_pkg::*;

  localparam int WL = 4;

  logic        clk, reset, core_active, core_clk_enable;
  logic [31:0] instr_address, instr_readdata;
  logic        data_read, data_write;
  logic [31:0] data_address, data_writedata, data_readdata;
  logic [3:0]  data_byteenable;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic        avm_read, avm_write, avm_waitrequest, bus_error;
  logic [3:0]  avm_byteenable;
`ifdef MIPS_ARB_PERF_EN
  logic [31:0] perf_steps, perf_wait_cycles;
`endif

  mips_cpu_bus_arbiter #(
    .WAIT_LIMIT(WL)
`ifdef MIPS_ARB_PERF_EN
    , .PERF_W(32)
`endif
  ) dut (
    .clk(clk), .reset(reset), .core_active(core_active), .core_clk_enable(core_clk_enable),
    .instr_address(instr_address), .instr_readdata(instr_readdata),
    .data_read(data_read), .data_write(data_write), .data_address(data_address),
    .data_byteenable(data_byteenable), .data_writedata(data_writedata), .data_readdata(data_readdata),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .bus_error(bus_error)
`ifdef MIPS_ARB_PERF_EN
    , .perf_steps(perf_steps), .perf_wait_cycles(perf_wait_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs to drive during it and outputs expected during it.
  typedef struct {
    logic        rst, chk, act, dr, dw, wt;
    logic [31:0] daddr, dwd, iaddr, rdata;
    logic [3:0]  dbe;
    logic        e_rd, e_wr, e_cke, e_err;
    logic [31:0] e_addr, e_wd, e_instr, e_dread;
    logic [3:0]  e_be;
    int          e_ps, e_pw, tag;
  } cyc_t;

  cyc_t        q[$];
  logic [31:0] m_instr, m_dread;
  logic        m_err;
  int          m_ps, m_pw, pend_tag;
  int          n_tests, n_fail;

  task automatic blank(output cyc_t c);
    c.rst = 1'b0; c.chk = 1'b1;
    c.act = 1'($urandom); c.dr = 1'($urandom); c.dw = 1'($urandom); c.wt = 1'($urandom);
    c.daddr = $urandom & 32'hFFFF_FFFC; c.dwd = $urandom; c.iaddr = $urandom; c.rdata = $urandom;
    c.dbe = 4'($urandom);
    c.e_rd = 1'b0; c.e_wr = 1'b0; c.e_cke = 1'b0; c.e_err = m_err;
    c.e_addr = '0; c.e_wd = '0; c.e_be = '0;
    c.e_instr = m_instr; c.e_dread = m_dread; c.e_ps = m_ps; c.e_pw = m_pw;
    c.tag = pend_tag; pend_tag = 0;
  endtask

  task automatic push(input cyc_t c);
    q.push_back(c);
    if (c.rst) begin
      m_instr = '0; m_dread = '0; m_err = 1'b0; m_ps = 0; m_pw = 0; pend_tag = 6;
    end else begin
      if (c.e_cke) m_ps++;
      if ((c.e_rd || c.e_wr) && c.wt) m_pw++;
    end
  endtask

  task automatic do_reset(input logic chk);
    cyc_t c;
    blank(c); c.rst = 1'b1; c.chk = chk; push(c);
  endtask

  task automatic go_error();
    cyc_t c;
    m_err = 1'b1;
    for (int i = 0; i < 5; i++) begin
      blank(c); c.tag = 5; push(c);
    end
  endtask

  // kind: 0 nop, 1 load, 2 store, 3 read+write (store). wd/wf: wait cycles of each transfer.
  task automatic step(input int kind, input int wd, input int wf, input logic [31:0] daddr,
                      input logic [3:0] dbe, input logic [31:0] dwd, input logic [31:0] iaddr,
                      input logic [31:0] idata, input logic [31:0] ddata, input int tg);
    cyc_t c;
    int   n;
    logic is_rd, is_wr;
    is_wr = (kind >= 2);
    is_rd = (kind == 1);
    blank(c);
    c.act = 1'b1; c.dr = (kind == 1 || kind == 3); c.dw = is_wr;
    c.daddr = daddr; c.dbe = dbe; c.dwd = dwd;
    if (kind == 0) c.iaddr = iaddr;
    push(c);
    if (kind != 0) begin
      n = (wd >= WL) ? WL : wd + 1;
      for (int i = 0; i < n; i++) begin
        blank(c);
        c.e_rd = is_rd; c.e_wr = is_wr; c.e_addr = daddr; c.e_be = dbe; c.e_wd = dwd;
        c.wt = (i < wd);
        if (!c.wt) begin c.rdata = ddata; c.iaddr = iaddr; end
        if (tg == 4 && i == 0) c.tag = 4;
        push(c);
      end
      if (wd >= WL) begin go_error(); return; end
      if (is_rd) m_dread = ddata;
    end
    n = (wf >= WL) ? WL : wf + 1;
    for (int i = 0; i < n; i++) begin
      blank(c);
      c.e_rd = 1'b1; c.e_addr = iaddr; c.e_be = 4'hF;
      c.wt = (i < wf);
      if (!c.wt) c.rdata = idata;
      if (tg == 2 && i == 0) c.tag = 1;
      push(c);
    end
    if (wf >= WL) begin go_error(); return; end
    m_instr = idata;
    blank(c); c.e_cke = 1'b1;
    if (tg == 2 || tg == 3) c.tag = tg;
    push(c);
  endtask

  task automatic mid_data_reset_then_halt();
    cyc_t c;
    blank(c); c.act = 1'b1; c.dr = 1'b1; c.dw = 1'b0; c.daddr = 32'h0000_0040; c.dbe = 4'hF; push(c);
    for (int i = 0; i < 3; i++) begin
      blank(c); c.e_rd = 1'b1; c.e_addr = 32'h0000_0040; c.e_be = 4'hF; c.wt = 1'b1;
      c.rst = (i == 2);
      push(c);
    end
    blank(c); c.act = 1'b0; push(c);
    for (int i = 0; i < 8; i++) begin
      blank(c); push(c);
    end
    do_reset(1'b1);
  endtask

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
    end
  endtask

  task automatic compare(input cyc_t c);
    check("avm_read", 32'(avm_read), 32'(c.e_rd));
    check("avm_write", 32'(avm_write), 32'(c.e_wr));
    check("core_clk_enable", 32'(core_clk_enable), 32'(c.e_cke));
    check("bus_error", 32'(bus_error), 32'(c.e_err));
    check("instr_readdata", instr_readdata, c.e_instr);
    check("data_readdata", data_readdata, c.e_dread);
    if (c.e_rd || c.e_wr) begin
      check("avm_address", avm_address, c.e_addr);
      check("avm_byteenable", 32'(avm_byteenable), 32'(c.e_be));
    end
    if (c.e_wr) check("avm_writedata", avm_writedata, c.e_wd);
`ifdef MIPS_ARB_PERF_EN
    check("perf_steps", perf_steps, 32'(c.e_ps));
    check("perf_wait_cycles", perf_wait_cycles, 32'(c.e_pw));
`endif
    case (c.tag)
      1: begin
        check("lit_nop_addr", avm_address, 32'hBFC00000);
        check("lit_nop_read", 32'(avm_read), 32'd1);
      end
      2: begin
        check("lit_nop_instr", instr_readdata, 32'h24020005);
        check("lit_nop_cke", 32'(core_clk_enable), 32'd1);
      end
      3: check("lit_load_data", data_readdata, 32'hDEADBEEF);
      4: begin
        check("lit_store_write", 32'(avm_write), 32'd1);
        check("lit_store_read", 32'(avm_read), 32'd0);
        check("lit_store_be", 32'(avm_byteenable), 32'h3);
        check("lit_store_data", avm_writedata, 32'h0000ABCD);
      end
      5: begin
        check("lit_err_flag", 32'(bus_error), 32'd1);
        check("lit_err_strobe", 32'(avm_read | avm_write), 32'd0);
        check("lit_err_cke", 32'(core_clk_enable), 32'd0);
      end
      6: begin
        check("lit_rst_addr", avm_address, 32'd0);
        check("lit_rst_be", 32'(avm_byteenable), 32'd0);
        check("lit_rst_wdata", avm_writedata, 32'd0);
        check("lit_rst_instr", instr_readdata, 32'd0);
        check("lit_rst_dread", data_readdata, 32'd0);
      end
`ifdef MIPS_ARB_PERF_EN
      7: begin
        check("lit_perf_steps", perf_steps, 32'd3);
        check("lit_perf_waits", perf_wait_cycles, 32'd5);
      end
`endif
      default: ;
    endcase
  endtask

  initial begin
    cyc_t c;
    int   kind, wd, wf;
    n_tests = 0; n_fail = 0;
    m_instr = '0; m_dread = '0; m_err = 1'b0; m_ps = 0; m_pw = 0; pend_tag = 0;
    reset = 1'b1; core_active = 1'b0; data_read = 1'b0; data_write = 1'b0;
    instr_address = '0; data_address = '0; data_byteenable = '0; data_writedata = '0;
    avm_readdata = '0; avm_waitrequest = 1'b0;

    do_reset(1'b0);
    do_reset(1'b0);
    step(0, 0, 0, 32'h0, 4'h0, 32'h0, RESET_VECTOR, 32'h24020005, 32'h0, 2);
    step(1, 2, 0, 32'h0000_1000, 4'hF, 32'h1111_2222, RESET_VECTOR + 32'd4, 32'h8C43_0000, 32'hDEADBEEF, 3);
    step(2, 0, 3, 32'h0000_2000, 4'b0011, 32'h0000_ABCD, RESET_VECTOR + 32'd8, 32'hAC43_0000, 32'h5555_5555, 4);
    pend_tag = 7;
    step(3, 1, 1, 32'h0000_3000, 4'hC, 32'h1234_5678, RESET_VECTOR + 32'd12, 32'h0000_0000, 32'h7777_7777, 0);
    step(0, 0, 7, 32'h0, 4'h0, 32'h0, RESET_VECTOR + 32'd16, 32'h0, 32'h0, 0);
    do_reset(1'b1);
    for (int s = 0; s < 150; s++) begin
      kind = int'($urandom_range(0, 3));
      wd = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 3));
      wf = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 3));
      step(kind, wd, wf, $urandom & 32'hFFFF_FFFC, 4'($urandom), $urandom,
           $urandom & 32'hFFFF_FFFC, $urandom, $urandom, 0);
      if (m_err) do_reset(1'b1);
    end
    mid_data_reset_then_halt();
    for (int s = 0; s < 10; s++) begin
      step(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           $urandom & 32'hFFFF_FFFC, 4'($urandom), $urandom, $urandom & 32'hFFFF_FFFC,
           $urandom, $urandom, 0);
    end

    while (q.size() > 0) begin
      @(negedge clk);
      c = q.pop_front();
      if (c.chk) compare(c);
      reset = c.rst; core_active = c.act; data_read = c.dr; data_write = c.dw;
      data_address = c.daddr; data_byteenable = c.dbe; data_writedata = c.dwd;
      instr_address = c.iaddr; avm_waitrequest = c.wt; avm_readdata = c.rdata;
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
